// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, parity constants and frame helper for the UART blocks
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam logic PARITY_SEL_EVEN = 1'b0;
   localparam logic PARITY_SEL_ODD  = 1'b1;

   // Number of bit periods in one frame, start bit through last stop bit.
   function automatic int unsigned frame_bits(input int unsigned data_width,
                                              input int unsigned parity_en,
                                              input int unsigned stop_bits);
      return 1 + data_width + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - baud counter raising bit_end in the last cycle of each bit period
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high
//   restart - forces the count back to 0 on the next edge
//   bit_end - high while the count is CLKS_PER_BIT-1
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - UART transmitter popping bytes from the TX FIFO
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high
//   fifo_empty   - TX FIFO empty flag
//   fifo_rd_data - TX FIFO registered read data, captured during LOAD
//   fifo_rd_en   - one-cycle pop strobe, high only in LOAD
//   tx           - registered serial line, idles high
//   busy         - high from LOAD through the end of the final stop bit
//   tx_done      - one-cycle pulse in the last cycle of the final stop bit
module uart_tx_fifo_reader
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic parity_sel = (PARITY_ODD != 0) ? PARITY_SEL_ODD : PARITY_SEL_EVEN;

   uart_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic                  stop_idx_q, stop_idx_d;
   logic                  tx_q, tx_d;
   logic                  bit_end;

   // Restarting during LOAD makes the START bit begin at count 0.
   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk    (clk),
      .reset  (reset),
      .restart(state_q == LOAD),
      .bit_end(bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      tx_done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = LOAD;
         end
         LOAD: begin
            shreg_d    = fifo_rd_data;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            state_d    = START;
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == LAST_IDX) begin
                  if (PARITY_EN != 0) state_d = PARITY;
                  else                state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (stop_idx_q == LAST_STOP) begin
                  tx_done = 1'b1;
                  // Chaining straight into LOAD gives exactly one idle-high cycle between frames.
                  if (fifo_empty) state_d = IDLE;
                  else            state_d = LOAD;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is derived from next-state values so the registered tx lines up with state_q.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[bit_idx_d];
         PARITY:  tx_d = (^shreg_d) ^ parity_sel;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         tx_q       <= tx_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE);
   assign fifo_rd_en = (state_q == LOAD);

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb/tb_uart_tx_fifo_reader.sv - directed self-checking bench for uart_tx_fifo_reader
module tb_uart_tx_fifo_reader;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] empty;
   logic [7:0] rdd [4];
   wire  [3:0] rd_en;
   wire  [3:0] tx;
   wire  [3:0] busy;
   wire  [3:0] done;

   logic [7:0] mem [4][8];
   int wp [4] = '{0, 0, 0, 0};
   int rp [4] = '{0, 0, 0, 0};
   int done_cnt [4] = '{0, 0, 0, 0};

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // inst0: plain 8N1, inst1: even parity, inst2: odd parity, inst3: two stop bits
   uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .fifo_empty(empty[0]), .fifo_rd_data(rdd[0]),
      .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));
   uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
      .clk(clk), .reset(reset), .fifo_empty(empty[1]), .fifo_rd_data(rdd[1]),
      .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));
   uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
      .clk(clk), .reset(reset), .fifo_empty(empty[2]), .fifo_rd_data(rdd[2]),
      .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));
   uart_tx_fifo_reader #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
      .clk(clk), .reset(reset), .fifo_empty(empty[3]), .fifo_rd_data(rdd[3]),
      .fifo_rd_en(rd_en[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(done[3]));

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         empty[i] = (wp[i] == rp[i]);
         rdd[i]   = mem[i][rp[i] % 8];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rd_en[i] === 1'b1) rp[i] <= rp[i] + 1;
         if (done[i] === 1'b1)  done_cnt[i] <= done_cnt[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] b);
      mem[idx][wp[idx] % 8] = b;
      wp[idx] = wp[idx] + 1;
   endtask

   task automatic wait_load(input int idx, input int max_cyc, output int n);
      n = 0;
      while (rd_en[idx] !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("load_seen%0d", idx), rd_en[idx], 1);
      chk($sformatf("load_tx_high%0d", idx), tx[idx], 1);
   endtask

   // bits[i] is the i-th transmitted bit; sampling starts in the cycle after LOAD.
   task automatic check_frame(input int idx, input string bits, input int exp_cycles);
      int done_n  = 0;
      int done_at = 0;
      int busy_lo = 0;
      int cyc     = 0;
      for (int i = 0; i < bits.len(); i++) begin
         logic e;
         int   good;
         e    = (bits[i] == "1");
         good = 0;
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            cyc++;
            if (tx[idx] === e) good++;
            if (done[idx] === 1'b1) begin
               done_n++;
               done_at = cyc;
            end
            if (busy[idx] !== 1'b1) busy_lo++;
         end
         chk($sformatf("frame%0d_bit%0d", idx, i), good, CPB);
      end
      chk($sformatf("frame%0d_done_count", idx), done_n, 1);
      chk($sformatf("frame%0d_done_cycle", idx), done_at, exp_cycles);
      chk($sformatf("frame%0d_busy", idx), busy_lo, 0);
   endtask

   initial begin
      int n;
      int d0;

      // Reset held 3 cycles with a byte already waiting
      reset = 1'b1;
      push(0, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", tx[0], 1);
         chk("rst_busy", busy[0], 0);
         chk("rst_rd_en", rd_en[0], 0);
         chk("rst_done", done[0], 0);
      end
      reset = 1'b0;

      // 0xA5, 8N1
      wait_load(0, 20, n);
      chk("first_load_latency", n, 1);
      check_frame(0, "0101001011", 40);
      @(negedge clk);
      chk("a5_busy_after", busy[0], 0);
      chk("a5_tx_idle", tx[0], 1);
      chk("a5_pops", rp[0], 1);

      // 0x07 with even and odd parity
      push(1, 8'h07);
      wait_load(1, 20, n);
      check_frame(1, "01110000011", 44);
      push(2, 8'h07);
      wait_load(2, 20, n);
      check_frame(2, "01110000001", 44);

      // Back-to-back 0x55, 0xAA
      push(0, 8'h55);
      push(0, 8'hAA);
      wait_load(0, 20, n);
      check_frame(0, "0101010101", 40);
      wait_load(0, 4, n);
      chk("b2b_gap", n, 1);
      check_frame(0, "0010101011", 40);
      @(negedge clk);
      chk("b2b_pops", rp[0], 3);
      chk("b2b_busy_after", busy[0], 0);

      // Reset during data bit 3 of 0xF0, then a clean 0x3C frame
      push(0, 8'hF0);
      wait_load(0, 20, n);
      repeat (4 + 12 + 2) @(negedge clk);
      chk("abort_in_bit3", tx[0], 0);
      d0 = done_cnt[0];
      reset = 1'b1;
      push(0, 8'h3C);
      @(negedge clk);
      chk("abort_tx", tx[0], 1);
      chk("abort_busy", busy[0], 0);
      chk("abort_done", done[0], 0);
      chk("abort_rd_en", rd_en[0], 0);
      reset = 1'b0;
      wait_load(0, 20, n);
      chk("abort_reload_latency", n, 1);
      check_frame(0, "0001111001", 40);
      @(negedge clk);
      chk("abort_done_total", done_cnt[0], d0 + 1);
      chk("abort_pops", rp[0], 5);

      // Two stop bits, 0x00
      push(3, 8'h00);
      wait_load(3, 20, n);
      check_frame(3, "00000000011", 44);

      repeat (3) @(negedge clk);
      chk("done_total0", done_cnt[0], 4);
      chk("done_total1", done_cnt[1], 1);
      chk("done_total2", done_cnt[2], 1);
      chk("done_total3", done_cnt[3], 1);
      chk("idle_busy_all", busy, 4'b0000);
      chk("idle_tx_all", tx, 4'b1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
